proc_run_checker: RTL and testbench
===================================

// Module: proc_run_checker
// PURPOSE
//   Synthesizable run controller and result checker for the single-cycle processor (singlecycle).
//   Drives the processor's resetl/startpc, then watches currentpc/MemtoRegOut until the program
//   reaches its end PC, compares the result to an expected value and keeps a pass tally.
//   It is the hardware counterpart of the directed program benches; it runs on FPGA or in sim.
// PARAMETERS
//   RESET_CYCLES  2    cycles resetl is held low per program (>=1)
//   WDOG_LIMIT    255  max RUN cycles before timeout (8..65535)
//   CNT_W         8    width of passCount/testCount (saturating)
// PORTS
//   CLK          in   1   system clock, all state on posedge
//   Reset        in   1   asynchronous, active-high controller reset
//   start        in   1   request new program check; sampled only in IDLE
//   skipReset    in   1   with start: continue from current PC, no processor reset
//   clearCounts  in   1   zero passCount/testCount
//   startPCIn    in   64  PC loaded into processor for this program
//   endPC        in   64  program finished when currentpc >= endPC (unsigned)
//   expected     in   64  required MemtoRegOut at finish
//   currentpc    in   64  from processor
//   MemtoRegOut  in   64  from processor
//   resetl       out  1   processor reset, active-low
//   startpc      out  64  processor start PC
//   busy         out  1   high in RESET/RUN/REPORT
//   done         out  1   one-cycle pulse when verdict is valid
//   pass         out  1   verdict of last program; held until next accepted start
//   timeout      out  1   last program hit WDOG_LIMIT; held until next accepted start
//   passCount    out  CNT_W  programs passed since clear
//   testCount    out  CNT_W  programs checked since clear
//   allPassed    out  1   (passCount==testCount) && testCount!=0
// BEHAVIOUR
//   Reset asserted: state=IDLE; resetl=0 (processor held in reset); startpc=0; busy=0; done=0;
//     pass=0; timeout=0; counts=0; watchdog=0. Reset mid-program aborts it, no count update.
//   States: IDLE -> RESET -> RUN -> REPORT -> IDLE.
//   IDLE: resetl keeps last value (0 after Reset). start=1 at edge N: latch startPCIn/endPC/
//     expected, clear pass/timeout. skipReset=0 -> RESET; skipReset=1 -> RUN, resetl/startpc unchanged.
//   RESET: resetl=0, startpc=latched startPCIn for exactly RESET_CYCLES cycles (N+1..N+RESET_CYCLES),
//     then resetl=1 from cycle N+RESET_CYCLES+1 and state=RUN.
//   RUN: watchdog cleared on entry, +1 per cycle. Each cycle compare currentpc >= endPC:
//     match -> pass=(MemtoRegOut==expected), sampled that same cycle; -> REPORT.
//     watchdog==WDOG_LIMIT with no match -> pass=0, timeout=1; -> REPORT.
//     match and expiry in same cycle: match wins, timeout=0.
//     endPC<=startpc: matches on first RUN cycle (legal, no special case).
//   REPORT (1 cycle): done=1; testCount+1; passCount+1 if pass; both saturate at 2^CNT_W-1.
//     Next cycle IDLE; resetl stays 1 so processor keeps running for a skipReset follow-on.
//   start while busy: ignored, not queued. clearCounts: any state; same cycle as REPORT
//     increment -> clear wins; counts read 0 next cycle.
//   Comparisons are unsigned 64-bit; no X propagation on outputs after Reset.
// TESTING
//   1 Reset=1 then release -> resetl=0, startpc=0, busy=0, counts 0, allPassed=0.
//   2 start, startPCIn=0, endPC=0x30, expected=0xF, model reaches PC 0x30 with 0xF -> resetl low
//     exactly 2 cycles, done pulse, pass=1, passCount=testCount=1, allPassed=1.
//   3 Then start+skipReset, endPC=0x54, expected=0x123456789ABCDEF0, model gives
//     0x123456789ABCDEF1 -> resetl never drops, pass=0, testCount=2, passCount=1, allPassed=0.
//   4 Model loops PC 0x10<->0x14, endPC=0x30 -> timeout=1, pass=0 after exactly 255 RUN cycles.
//   5 Reset pulse mid-RUN -> IDLE, resetl=0, no done, counts=0; start during busy ignored.
//   6 clearCounts in the REPORT cycle -> counts 0 next cycle; 256 passes with CNT_W=8 -> 255.

Source files
------------

// File: rtl/proc_run_checker.sv
// Run controller and result checker for the single-cycle processor: resets it,
// lets it run to an end PC, checks the result and keeps saturating tallies.
`timescale 1ns/1ps
module proc_run_checker #(
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_LIMIT   = 255,
  parameter int CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             skipReset,
  input  logic             clearCounts,
  input  logic [63:0]      startPCIn,
  input  logic [63:0]      endPC,
  input  logic [63:0]      expected,
  input  logic [63:0]      currentpc,
  input  logic [63:0]      MemtoRegOut,
  output logic             resetl,
  output logic [63:0]      startpc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] passCount,
  output logic [CNT_W-1:0] testCount,
  output logic             allPassed
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_REPORT} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   rst_cnt;
  logic [15:0]     wdog;
  logic [16:0]     wdog_inc;
  logic [63:0]     end_pc_q;
  logic [63:0]     expected_q;
  logic            reached;
  logic            expired;
  logic            reset_done;

  assign wdog_inc   = {1'b0, wdog} + 17'd1;
  assign reached    = (currentpc >= end_pc_q);
  assign expired    = (wdog_inc == 17'(WDOG_LIMIT));
  assign reset_done = (rst_cnt == RW'(RESET_CYCLES));
  assign allPassed  = (passCount == testCount) && (testCount != '0);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = (state == S_REPORT);
    case (state)
      S_IDLE:   if (start) state_next = skipReset ? S_RUN : S_RESET;
      S_RESET:  if (reset_done) state_next = S_RUN;
      S_RUN:    if (reached || expired) state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Program setup, processor reset sequencing and the RUN-phase verdict.
  // A match on the expiry cycle still counts as a normal finish.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      resetl     <= 1'b0;
      startpc    <= '0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      rst_cnt    <= '0;
      wdog       <= '0;
      end_pc_q   <= '0;
      expected_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            end_pc_q   <= endPC;
            expected_q <= expected;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            wdog       <= '0;
            if (!skipReset) begin
              resetl  <= 1'b0;
              startpc <= startPCIn;
              rst_cnt <= RW'(1);
            end
          end
        end
        S_RESET: begin
          if (reset_done) begin
            resetl <= 1'b1;
            wdog   <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_RUN: begin
          if (reached) begin
            pass    <= (MemtoRegOut == expected_q);
            timeout <= 1'b0;
          end else if (expired) begin
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wdog <= wdog_inc[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Tallies update as REPORT ends; a simultaneous clear takes priority.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      passCount <= '0;
      testCount <= '0;
    end else if (clearCounts) begin
      passCount <= '0;
      testCount <= '0;
    end else if (state == S_REPORT) begin
      if (testCount != CNT_MAX) testCount <= testCount + CNT_W'(1);
      if (pass && (passCount != CNT_MAX)) passCount <= passCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_proc_run_checker.sv
// Directed bench for proc_run_checker: a small processor model stepping the PC,
// a table of program runs and hand-written reset / clear / saturation sequences.
`timescale 1ns/1ps
module tb_proc_run_checker;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        start, skipReset, clearCounts;
  logic [63:0] startPCIn, endPC, expected, MemtoRegOut;
  logic [63:0] currentpc = 64'h0;
  logic        resetl, busy, done, pass, timeout, allPassed;
  logic [63:0] startpc;
  logic [7:0]  passCount, testCount;

  logic        loop_mode = 1'b0;
  logic        match_all = 1'b0;
  logic [63:0] target_pc = 64'h0;
  logic [63:0] mem_val = 64'h0;

  int checks = 0;
  int errors = 0;

  proc_run_checker dut (
    .CLK(CLK), .Reset(Reset), .start(start), .skipReset(skipReset),
    .clearCounts(clearCounts), .startPCIn(startPCIn), .endPC(endPC),
    .expected(expected), .currentpc(currentpc), .MemtoRegOut(MemtoRegOut),
    .resetl(resetl), .startpc(startpc), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .passCount(passCount), .testCount(testCount),
    .allPassed(allPassed)
  );

  always #5 CLK = ~CLK;

  // Processor model: loads startpc while held in reset, otherwise steps by 4
  // or bounces between 0x10 and 0x14 to emulate a program that never ends.
  always @(posedge CLK) begin
    if (!resetl)        currentpc <= startpc;
    else if (loop_mode) currentpc <= (currentpc == 64'h10) ? 64'h14 : 64'h10;
    else                currentpc <= currentpc + 64'd4;
  end

  assign MemtoRegOut = (match_all || currentpc == target_pc) ? mem_val : 64'h0;

  typedef struct {
    logic        skip;
    logic [63:0] sp, ep, ex, tgt, mv;
    logic        loop;
    logic        e_pass, e_to;
    int          e_lows, e_runs, e_pc, e_tc;
    logic        e_all;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Launches one program at a negedge and follows it to its done pulse.
  task automatic applyStimulus(
    input logic skip, input logic [63:0] sp, ep, ex, tgt, mv,
    input logic loop, input logic mall, input logic clr,
    output logic seen, output int lows, output int runs,
    output logic p, output logic to);
    skipReset = skip; startPCIn = sp; endPC = ep; expected = ex;
    target_pc = tgt; mem_val = mv; loop_mode = loop; match_all = mall;
    start = 1'b1;
    seen = 1'b0; lows = 0; runs = 0; p = 1'b0; to = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (!resetl) lows++;
      if (busy && !done && resetl) runs++;
      if (done) begin
        seen = 1'b1;
        p = pass;
        to = timeout;
        if (clr) clearCounts = 1'b1;
      end
    end
    @(negedge CLK);
    clearCounts = 1'b0;
  endtask

  initial begin
    logic seen, p, to;
    int lows, runs, done_cnt, busy_cnt;

    start = 1'b0; skipReset = 1'b0; clearCounts = 1'b0;
    startPCIn = '0; endPC = '0; expected = '0;

    vecs[0] = '{1'b0, 64'h0,   64'h30,  64'hF, 64'h30, 64'hF, 1'b0, 1'b1, 1'b0, 2, 13, 1, 1, 1'b1};
    vecs[1] = '{1'b1, 64'h0,   64'h54,  64'h123456789ABCDEF0, 64'h54, 64'h123456789ABCDEF1,
                1'b0, 1'b0, 1'b0, 0, -1, 1, 2, 1'b0};
    vecs[2] = '{1'b0, 64'h100, 64'h80,  64'hAB, 64'h100, 64'hAB, 1'b0, 1'b1, 1'b0, 2, 1, 2, 3, 1'b0};
    vecs[3] = '{1'b0, 64'h10,  64'h30,  64'h0,  64'h0,   64'h0,  1'b1, 1'b0, 1'b1, 2, 255, 2, 4, 1'b0};
    vecs[4] = '{1'b0, 64'h0,   64'h3F8, 64'h77, 64'h3F8, 64'h77, 1'b0, 1'b1, 1'b0, 2, 255, 3, 5, 1'b0};
    vecs[5] = '{1'b0, 64'h0,   64'h3FC, 64'h77, 64'h3FC, 64'h77, 1'b0, 1'b0, 1'b1, 2, 255, 3, 6, 1'b0};
    vecs[6] = '{1'b0, 64'h200, 64'h208, 64'h55, 64'h208, 64'h55, 1'b0, 1'b1, 1'b0, 2, 3, 4, 7, 1'b0};

    #1 Reset = 1'b1;
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("rst_resetl", resetl, 1'b0);
    checkOutput("rst_startpc", startpc, 64'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass_cnt", passCount, 8'd0);
    checkOutput("rst_test_cnt", testCount, 8'd0);
    checkOutput("rst_all", allPassed, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].skip, vecs[i].sp, vecs[i].ep, vecs[i].ex, vecs[i].tgt,
                    vecs[i].mv, vecs[i].loop, 1'b0, 1'b0, seen, lows, runs, p, to);
      checkOutput($sformatf("v%0d_done", i), seen, 1'b1);
      checkOutput($sformatf("v%0d_pass", i), p, vecs[i].e_pass);
      checkOutput($sformatf("v%0d_timeout", i), to, vecs[i].e_to);
      checkOutput($sformatf("v%0d_resetl_lows", i), 64'(lows), 64'(vecs[i].e_lows));
      if (vecs[i].e_runs >= 0)
        checkOutput($sformatf("v%0d_run_cycles", i), 64'(runs), 64'(vecs[i].e_runs));
      checkOutput($sformatf("v%0d_pass_cnt", i), passCount, 8'(vecs[i].e_pc));
      checkOutput($sformatf("v%0d_test_cnt", i), testCount, 8'(vecs[i].e_tc));
      checkOutput($sformatf("v%0d_all", i), allPassed, vecs[i].e_all);
      checkOutput($sformatf("v%0d_done_pulse", i), done, 1'b0);
      checkOutput($sformatf("v%0d_busy_after", i), busy, 1'b0);
      checkOutput($sformatf("v%0d_resetl_after", i), resetl, 1'b1);
    end

    applyStimulus(1'b0, 64'h200, 64'h208, 64'h55, 64'h208, 64'h55, 1'b0, 1'b0, 1'b1,
                  seen, lows, runs, p, to);
    checkOutput("clr_done", seen, 1'b1);
    checkOutput("clr_pass", p, 1'b1);
    checkOutput("clr_pass_cnt", passCount, 8'd0);
    checkOutput("clr_test_cnt", testCount, 8'd0);
    checkOutput("clr_all", allPassed, 1'b0);

    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 64'h0, 64'h0, 64'h5A, 64'h0, 64'h5A, 1'b0, 1'b1, 1'b0,
                    seen, lows, runs, p, to);
      if (seen) done_cnt++;
    end
    checkOutput("sat_done_cnt", 64'(done_cnt), 64'd256);
    checkOutput("sat_pass_cnt", passCount, 8'd255);
    checkOutput("sat_test_cnt", testCount, 8'd255);
    checkOutput("sat_all", allPassed, 1'b1);

    // Launch a never-ending program, try to restart it, then abort with Reset.
    skipReset = 1'b0; startPCIn = 64'h10; endPC = 64'h30; expected = 64'h0;
    loop_mode = 1'b1; match_all = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge CLK);
    skipReset = 1'b1; endPC = 64'h0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done) done_cnt++;
    end
    checkOutput("busy_start_ignored", 64'(done_cnt), 64'd0);
    checkOutput("busy_still_running", busy, 1'b1);
    Reset = 1'b1;
    #1;
    checkOutput("abort_resetl", resetl, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_startpc", startpc, 64'h0);
    checkOutput("abort_pass_cnt", passCount, 8'd0);
    checkOutput("abort_test_cnt", testCount, 8'd0);
    @(negedge CLK);
    Reset = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_idle", 64'(busy_cnt), 64'd0);
    checkOutput("abort_timeout", timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
